pipelined_seg_adder: RTL



---
 rtl/pipelined_seg_adder_pkg.sv | 13 +
 rtl/pipelined_seg_adder_seg_add_stage.sv | 21 ++
 rtl/pipelined_seg_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipelined_seg_adder_pkg.sv
// Shared helpers for the segmented pipelined adder: segment count and
// parameter legality check.
package pipelined_seg_adder_pkg;

  function automatic int nseg(input int w, input int s);
    return (s > 0) ? (w / s) : 0;
  endfunction

  function automatic bit seg_ok(input int w, input int s);
    return (s > 0) && (w >= s) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/pipelined_seg_adder_seg_add_stage.sv
// Combinational S-bit adder slice; also reports the carry into its own MSB
// so the top segment can derive signed overflow.
module seg_add_stage #(
  parameter int S = 8
) (
  input  logic [S-1:0] a_seg,
  input  logic [S-1:0] b_seg,
  input  logic         ci,
  output logic [S-1:0] s_seg,
  output logic         co,
  output logic         msb_ci
);

  logic [S:0] total;

  assign total  = {1'b0, a_seg} + {1'b0, b_seg} + {{S{1'b0}}, ci};
  assign s_seg  = total[S-1:0];
  assign co     = total[S];
  assign msb_ci = a_seg[S-1] ^ b_seg[S-1] ^ s_seg[S-1];

endmodule

// File: rtl/pipelined_seg_adder.sv
// W-bit add/subtract resolved one S-bit segment per pipeline stage; the
// carry between segments crosses exactly one register.
module pipelined_seg_adder
  import pipelined_seg_adder_pkg::*;
#(
  parameter int W = 16,
  parameter int S = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NSEG = nseg(W, S);

  generate
    if (!seg_ok(W, S)) begin : g_bad_params
      $error("pipelined_seg_adder: W must be a non-zero multiple of S");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe advances as one unit whenever the last stage is empty
  // or its result is being taken, so in_ready never depends on in_valid.
  logic adv;

  logic         v_r   [NSEG];
  logic [W-1:0] a_r   [NSEG];
  logic [W-1:0] b_r   [NSEG];
  logic [W-1:0] sum_r [NSEG];
  logic         c_r   [NSEG];
  logic         msb_r;

  logic         v_in   [NSEG];
  logic [W-1:0] a_in   [NSEG];
  logic [W-1:0] b_in   [NSEG];
  logic [W-1:0] sum_in [NSEG];
  logic         ci_in  [NSEG];
  logic [W-1:0] sum_nx [NSEG];

  logic [S-1:0] s_seg [NSEG];
  logic         co_w  [NSEG];
  logic         msb_w [NSEG];

  assign adv      = !v_r[NSEG-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    // Stage 0 sees the conditioned operands; later stages see the skew buffer.
    v_in[0]   = in_valid && adv;
    a_in[0]   = a;
    b_in[0]   = b ^ {W{sub}};
    ci_in[0]  = sub | cin;
    sum_in[0] = '0;
    for (int k = 1; k < NSEG; k++) begin
      v_in[k]   = v_r[k-1];
      a_in[k]   = a_r[k-1];
      b_in[k]   = b_r[k-1];
      ci_in[k]  = c_r[k-1];
      sum_in[k] = sum_r[k-1];
    end
    for (int k = 0; k < NSEG; k++) begin
      sum_nx[k]            = sum_in[k];
      sum_nx[k][k*S +: S]  = s_seg[k];
    end
  end

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    seg_add_stage #(.S(S)) u_seg (
      .a_seg  (a_in[g][g*S +: S]),
      .b_seg  (b_in[g][g*S +: S]),
      .ci     (ci_in[g]),
      .s_seg  (s_seg[g]),
      .co     (co_w[g]),
      .msb_ci (msb_w[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        v_r[k]   <= 1'b0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        sum_r[k] <= '0;
        c_r[k]   <= 1'b0;
      end
      msb_r <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSEG; k++) begin
        v_r[k]   <= v_in[k];
        a_r[k]   <= a_in[k];
        b_r[k]   <= b_in[k];
        sum_r[k] <= sum_nx[k];
        c_r[k]   <= co_w[k];
      end
      msb_r <= msb_w[NSEG-1];
    end
  end

  assign out_valid = v_r[NSEG-1];
  assign sum       = sum_r[NSEG-1];
  assign cout      = c_r[NSEG-1];
  assign ovf       = msb_r ^ c_r[NSEG-1];

endmodule
